// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master
//   Converts a simple valid/ready command port into single AXI4-Lite
//   transactions. Only one transaction is outstanding at any time.
//   A write drives AW and W together and waits for B. A read drives AR
//   and waits for R. Completion is reported as a one-cycle rsp_valid pulse.
//
// Ports
//   ACLK, ARESETn                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready high only in IDLE)
//   cmd_we, cmd_addr, cmd_wdata   command payload (wdata ignored for reads)
//   rsp_valid, rsp_rdata, rsp_err completion pulse, read data (0 on writes),
//                                 and RESP[1] (SLVERR/DECERR)
//   AW*/W*/B*/AR*/R*              AXI4-Lite master channels
module axi_lite_cmd_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    // command / response port
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    // write address
    output logic [ADDR_W-1:0]   AWADDR,
    output logic                AWVALID,
    input  logic                AWREADY,
    // write data
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WVALID,
    input  logic                WREADY,
    // write response
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    // read address
    output logic [ADDR_W-1:0]   ARADDR,
    output logic                ARVALID,
    input  logic                ARREADY,
    // read data
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RVALID,
    output logic                RREADY
);

    typedef enum logic [2:0] {IDLE, WREQ, WRSP, RREQ, RRSP} state_t;

    state_t state;
    logic   aw_done;   // AW handshake already completed for this write
    logic   w_done;    // W handshake already completed for this write
    logic   aw_fire;
    logic   w_fire;
    logic   unused_resp_lsb;

    // Full-word writes only.
    assign WSTRB   = '1;

    // Only RESP[1] distinguishes error from OKAY/EXOKAY.
    assign unused_resp_lsb = BRESP[0] ^ RRESP[0];

    // Handshake detection uses the registered VALIDs; no VALID ever
    // depends on a READY in the same cycle.
    assign aw_fire = AWVALID & AWREADY;
    assign w_fire  = WVALID & WREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            AWADDR    <= '0;
            AWVALID   <= 1'b0;
            WDATA     <= '0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARADDR    <= '0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            // Response outputs are a single-cycle pulse; zero otherwise.
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_we) begin
                            state   <= WREQ;
                            AWADDR  <= cmd_addr;
                            WDATA   <= cmd_wdata;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                        end else begin
                            state   <= RREQ;
                            ARADDR  <= cmd_addr;
                            ARVALID <= 1'b1;
                        end
                    end
                end

                WREQ: begin
                    // AW and W retire independently; payload registers are
                    // untouched here so they stay stable while VALID is up.
                    if (aw_fire) begin
                        AWVALID <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_fire) begin
                        WVALID <= 1'b0;
                        w_done <= 1'b1;
                    end
                    // Include this cycle's handshakes so a same-cycle
                    // completion reaches WRSP on the very next cycle.
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        state  <= WRSP;
                        BREADY <= 1'b1;
                    end
                end

                WRSP: begin
                    if (BVALID) begin
                        state     <= IDLE;
                        BREADY    <= 1'b0;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= BRESP[1];
                    end
                end

                RREQ: begin
                    if (ARREADY) begin
                        state   <= RRSP;
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                    end
                end

                RRSP: begin
                    if (RVALID) begin
                        state     <= IDLE;
                        RREADY    <= 1'b0;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= RDATA;
                        rsp_err   <= RRESP[1];
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/axi_lite_cmd_master.md
AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of the address on the command port and on AWADDR/ARADDR.
REQ-002 SHALL have parameter DATA_W, default 32 (32 or 64): width of the data path; WSTRB is DATA_W/8 bits wide.
REQ-003 SHALL have port ACLK  input  1  the single clock.
REQ-004 SHALL have port ARESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_we  input  1  1=write, 0=read.
REQ-008 SHALL have port cmd_addr  input  ADDR_W  byte address.
REQ-009 SHALL have port cmd_wdata  input  DATA_W  write data; ignored for reads.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  DATA_W  read data; 0 for writes.
REQ-012 SHALL have port rsp_err  output  1  copy of BRESP[1] or RRESP[1] (SLVERR/DECERR).
REQ-013 SHALL have port AWADDR  output  ADDR_W  write address.
REQ-014 SHALL have port AWVALID  output  1.
REQ-015 SHALL have port AWREADY  input  1.
REQ-016 SHALL have port WDATA  output  DATA_W.
REQ-017 SHALL have port WSTRB  output  DATA_W/8  always all ones.
REQ-018 SHALL have port WVALID  output  1.
REQ-019 SHALL have port WREADY  input  1.
REQ-020 SHALL have port BRESP  input  2.
REQ-021 SHALL have port BVALID  input  1.
REQ-022 SHALL have port BREADY  output  1.
REQ-023 SHALL have port ARADDR  output  ADDR_W  read address.
REQ-024 SHALL have port ARVALID  output  1.
REQ-025 SHALL have port ARREADY  input  1.
REQ-026 SHALL have port RDATA  input  DATA_W.
REQ-027 SHALL have port RRESP  input  2.
REQ-028 SHALL have port RVALID  input  1.
REQ-029 SHALL have port RREADY  output  1.

Function
REQ-030 SHALL implement FSM states IDLE, WREQ, WRSP, RREQ, RRSP; only one transaction outstanding at any time.
REQ-031 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&cmd_ready, SHALL register cmd_addr/cmd_wdata and go to WREQ (cmd_we=1) or RREQ (cmd_we=0).
REQ-032 In WREQ, SHALL assert AWVALID and WVALID from the first WREQ cycle; each SHALL stay high with stable payload until its own READY is sampled high, then drop the next cycle.
REQ-033 AW and W handshakes SHALL complete independently in either order or the same cycle; WREQ->WRSP the cycle after both have completed.
REQ-034 In WRSP, SHALL hold BREADY=1; on BVALID, SHALL return to IDLE and pulse rsp_valid for one cycle with rsp_err=BRESP[1], rsp_rdata=0.
REQ-035 In RREQ, SHALL hold ARVALID=1 until ARREADY, then go to RRSP; in RRSP, SHALL hold RREADY=1; on RVALID, SHALL return to IDLE and pulse rsp_valid with rsp_rdata=RDATA, rsp_err=RRESP[1].
REQ-036 rsp_valid SHALL be registered: high exactly the cycle after the B/R handshake, coinciding with cmd_ready=1 in IDLE, so back-to-back commands are accepted with no idle cycle.
REQ-037 Latency with zero-wait slave: accept at cycle 0, AW/W or AR handshake cycle 1, B/R handshake cycle 2, rsp_valid cycle 3.
REQ-038 BREADY/RREADY SHALL be 0 outside WRSP/RRSP; no VALID SHALL depend combinationally on any READY.

Reset
REQ-039 On ARESETn low, SHALL immediately enter IDLE with cmd_ready=1 and all other outputs 0; an in-flight transaction SHALL be aborted with no rsp_valid.

Verification
REQ-040 Write addr 0x10, data 0xDEADBEEF, zero-wait slave, BRESP=00 -> AWADDR=0x10/WDATA=0xDEADBEEF/WSTRB=0xF cycle 1, rsp_valid cycle 3, rsp_err=0.
REQ-041 Write with WREADY 3 cycles before AWREADY -> WVALID drops after W handshake, AWVALID held with stable AWADDR, BREADY only after both, one rsp.
REQ-042 Read addr 0x24, ARREADY delayed 4 cycles, RDATA=0x12345678, RRESP=10 -> ARADDR stable, rsp_rdata=0x12345678, rsp_err=1.
REQ-043 Back-to-back read then write, cmd_valid held high -> second command accepted in the rsp_valid cycle of the first.
REQ-044 ARESETn low while in WRSP -> all VALID/READY outputs 0 asynchronously, no rsp_valid, next command after release processed normally.
